// File: rtl/return_addr_stack_pkg.sv
// Shared definitions for the return-address stack: default sizing tied to the PC
// and the push/pop opcode decode.
package return_addr_stack_pkg;

  localparam int RAS_PC_WIDTH = 10;
  localparam int RAS_DEPTH    = 8;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } ras_op_e;

endpackage

// File: rtl/ras_mem.sv
// Return-address storage: DEPTH x WIDTH register file, one synchronous write port,
// one asynchronous read port, no reset.
module ras_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Hardware return-address stack for CALL/RET. Top-of-stack is combinational so a RET
// can redirect the PC in its own cycle; pointer, occupancy and error flags update on the edge.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int WIDTH    = RAS_PC_WIDTH,
  parameter int DEPTH    = RAS_DEPTH,
  parameter bit OVF_WRAP = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           top,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int SPW = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);

  logic [SPW-1:0]   r_sp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic [SPW-1:0]   w_top_addr;
  logic [WIDTH-1:0] w_rdata;
  ras_op_e          w_op;

  logic             w_we;
  logic [SPW-1:0]   w_waddr;
  logic [SPW-1:0]   w_sp_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_top_addr = r_sp - SPW'(1);
  assign w_op       = ras_op_e'({push, pop});

  always_comb begin
    w_we        = 1'b0;
    w_waddr     = r_sp;
    w_sp_nxt    = r_sp;
    w_count_nxt = r_count;
    w_ovf_evt   = 1'b0;
    w_unf_evt   = 1'b0;
    case (w_op)
      OP_PUSH: begin
        if (!w_full) begin
          w_we        = 1'b1;
          w_sp_nxt    = r_sp + SPW'(1);
          w_count_nxt = r_count + CW'(1);
        end else begin
          w_ovf_evt = 1'b1;
          // Circular mode: the slot at sp holds the oldest entry once full.
          if (OVF_WRAP) begin
            w_we     = 1'b1;
            w_sp_nxt = r_sp + SPW'(1);
          end
        end
      end
      OP_POP: begin
        if (!w_empty) begin
          w_sp_nxt    = r_sp - SPW'(1);
          w_count_nxt = r_count - CW'(1);
        end else begin
          w_unf_evt = 1'b1;
        end
      end
      OP_REPL: begin
        w_we = 1'b1;
        if (!w_empty) begin
          w_waddr = w_top_addr;
        end else begin
          w_sp_nxt    = r_sp + SPW'(1);
          w_count_nxt = CW'(1);
          w_unf_evt   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_sp    <= w_sp_nxt;
      r_count <= w_count_nxt;
      // A new error on the same edge as err_clr keeps the flag set.
      r_ovf   <= w_ovf_evt | (r_ovf & ~err_clr);
      r_unf   <= w_unf_evt | (r_unf & ~err_clr);
    end
  end

  ras_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (push_data),
    .i_raddr (w_top_addr),
    .o_rdata (w_rdata)
  );

  assign top           = w_empty ? '0 : w_rdata;
  assign empty         = w_empty;
  assign full          = w_full;
  assign count         = r_count;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack at DEPTH=4: a saturating and a circular instance
// share all stimulus and are checked against hand-computed values.
module tb_return_addr_stack;

  localparam int W = 10;
  localparam int D = 4;

  logic         clk;
  logic         reset;
  logic         push;
  logic         pop;
  logic [W-1:0] push_data;
  logic         err_clr;

  logic [W-1:0] top0, top1;
  logic         empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;
  logic [2:0]   count0, count1;

  int n_vec  = 0;
  int n_miss = 0;

  return_addr_stack #(.WIDTH(W), .DEPTH(D), .OVF_WRAP(1'b0)) dut_sat (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
    .err_clr(err_clr), .top(top0), .empty(empty0), .full(full0), .count(count0),
    .overflow_err(ovf0), .underflow_err(unf0)
  );

  return_addr_stack #(.WIDTH(W), .DEPTH(D), .OVF_WRAP(1'b1)) dut_wrap (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
    .err_clr(err_clr), .top(top1), .empty(empty1), .full(full1), .count(count1),
    .overflow_err(ovf1), .underflow_err(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one operation across a rising edge; outputs are sampled 1ns after it.
  task automatic step(input logic p, input logic q, input logic [W-1:0] d, input logic c);
    push = p; pop = q; push_data = d; err_clr = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; push_data = '0; err_clr = 1'b0;
  endtask

  task automatic do_push(input logic [W-1:0] d);
    step(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic do_pop();
    step(1'b0, 1'b1, '0, 1'b0);
  endtask

  int exp_sat [4] = '{4, 3, 2, 1};
  int exp_wrp [4] = '{5, 4, 3, 2};

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state, underflow, clear
    check("rst_top",   top0, 0);
    check("rst_empty", empty0, 1);
    check("rst_full",  full0, 0);
    check("rst_count", count0, 0);
    check("rst_errs",  {ovf0, unf0, ovf1, unf1}, 0);
    do_pop();
    check("unf_top",   top0, 0);
    check("unf_count", count0, 0);
    check("unf_flag",  unf0, 1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("unf_clr",   unf0, 0);

    // 2: basic push/pop
    do_push(10'h010); do_push(10'h020); do_push(10'h030);
    check("p3_top",   top0, 'h030);
    check("p3_count", count0, 3);
    do_pop();  check("pop1_top", top0, 'h020);
    do_pop();  check("pop2_top", top0, 'h010);
    do_pop();  check("pop3_top", top0, 0);
    check("pop3_empty", empty0, 1);
    check("pop3_errs",  {ovf0, unf0}, 0);

    // 3/4: full behaviour on both policies
    for (int i = 1; i <= 4; i++) do_push(W'(i));
    check("full_sat",  full0, 1);
    check("full_wrap", full1, 1);
    do_push(10'd5);
    check("ovf_sat_top",   top0, 4);
    check("ovf_sat_count", count0, 4);
    check("ovf_sat_flag",  ovf0, 1);
    check("ovf_wrp_top",   top1, 5);
    check("ovf_wrp_count", count1, 4);
    check("ovf_wrp_flag",  ovf1, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sat_ret%0d", i), top0, exp_sat[i]);
      check($sformatf("wrp_ret%0d", i), top1, exp_wrp[i]);
      do_pop();
    end
    check("drain_empty_sat",  empty0, 1);
    check("drain_empty_wrap", empty1, 1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("ovf_clr", {ovf0, ovf1}, 0);

    // replace while full: no overflow
    for (int i = 1; i <= 4; i++) do_push(W'(8 * i));
    step(1'b1, 1'b1, 10'h3FF, 1'b0);
    check("repl_full_top",   top0, 'h3FF);
    check("repl_full_count", count0, 4);
    check("repl_full_ovf",   ovf0, 0);
    do_pop();
    check("repl_full_below", top0, 24);
    repeat (3) do_pop();

    // 5: tail-call replace and replace-on-empty
    do_push(10'h100);
    step(1'b1, 1'b1, 10'h155, 1'b0);
    check("tail_top",   top0, 'h155);
    check("tail_count", count0, 1);
    check("tail_unf",   unf0, 0);
    do_pop();
    step(1'b1, 1'b1, 10'h0AA, 1'b0);
    check("repl_empty_count", count0, 1);
    check("repl_empty_unf",   unf0, 1);
    check("repl_empty_top",   top0, 'h0AA);
    do_pop();
    step(1'b0, 1'b0, '0, 1'b1);

    // 6: async reset between edges, then clear racing an underflow
    do_push(10'h011); do_push(10'h022); do_push(10'h033);
    #2 reset = 1'b1;
    #1;
    check("arst_top",   top0, 0);
    check("arst_count", count0, 0);
    check("arst_empty", empty0, 1);
    #1 reset = 1'b0;
    step(1'b0, 1'b1, '0, 1'b1);
    check("clr_vs_set_unf", unf0, 1);
    check("clr_vs_set_top", top0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
